// File: rtl/frame_fetch_scheduler.sv
// Burst-read sequencer for one source frame in DDR, paced by pixel-FIFO space and restarted on VTG vsync.
// Build with DOUBLE_BUFFER_EN defined to alternate between frame_base and frame_base_alt on swap_req.
module frame_fetch_scheduler #(
  parameter int FRAME_PIXELS = 76800,
  parameter int BURST_PIXELS = 64,
  parameter int FIFO_DEPTH   = 1024,
  parameter int FIFO_AW      = 10,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [ADDR_W-1:0] frame_base_alt,
  input  logic              swap_req,
  input  logic              vsync_in,
  input  logic [FIFO_AW:0]  fifo_level,
  input  logic              fifo_empty,
  input  logic              fifo_rd_en,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  input  logic              rd_done,
  output logic              fifo_flush,
  output logic              frame_active,
  output logic              underflow,
  output logic              late_frame
);

  localparam int BURSTS = FRAME_PIXELS / BURST_PIXELS;
  localparam int CNT_W  = $clog2(BURSTS + 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] FLUSH      = 3'd1;
  localparam logic [2:0] WAIT_SPACE = 3'd2;
  localparam logic [2:0] ISSUE      = 3'd3;
  localparam logic [2:0] WAIT_DONE  = 3'd4;
  localparam logic [2:0] DONE       = 3'd5;

  logic [2:0]         state_reg, state_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               late_reg, late_next;
  logic               restart_reg, restart_next;
  logic               vsync_d_reg;
  logic               underflow_reg;
  logic               fs;
  logic [FIFO_AW+1:0] space;
  logic               space_ok;
  logic [ADDR_W-1:0]  base_sel;

  assign fs       = vsync_d_reg & ~vsync_in;
  assign space    = (FIFO_AW+2)'(FIFO_DEPTH) - {1'b0, fifo_level};
  assign space_ok = space >= (FIFO_AW+2)'(BURST_PIXELS);

`ifdef DOUBLE_BUFFER_EN
  logic buf_sel_reg;
  logic swap_pending_reg;
  logic buf_sel_flush;

  // The buffer chosen at FLUSH already reflects a swap requested before this frame.
  assign buf_sel_flush = buf_sel_reg ^ swap_pending_reg;
  assign base_sel      = buf_sel_flush ? frame_base_alt : frame_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_sel_reg      <= 1'b0;
      swap_pending_reg <= 1'b0;
    end else if (state_reg == FLUSH) begin
      buf_sel_reg      <= buf_sel_flush;
      swap_pending_reg <= swap_req;
    end else if (swap_req) begin
      swap_pending_reg <= 1'b1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{frame_base_alt, swap_req};
  assign base_sel      = frame_base;
`endif

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    cnt_next     = cnt_reg;
    late_next    = late_reg;
    restart_next = restart_reg;
    case (state_reg)
      IDLE: begin
        if (enable && fs) state_next = FLUSH;
      end
      FLUSH: begin
        addr_next    = base_sel;
        cnt_next     = '0;
        restart_next = 1'b0;
        state_next   = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (fs) begin
          late_next  = 1'b1;
          state_next = FLUSH;
        end else if (space_ok) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_next = WAIT_DONE;
          if (fs) begin
            late_next    = 1'b1;
            restart_next = 1'b1;
          end
        end else if (fs) begin
          late_next  = 1'b1;
          state_next = FLUSH;
        end
      end
      WAIT_DONE: begin
        if (fs) begin
          late_next    = 1'b1;
          restart_next = 1'b1;
        end
        // A late vsync discards the in-flight burst's count once its data has landed.
        if (rd_done) begin
          if (restart_reg || fs) begin
            state_next = FLUSH;
          end else begin
            cnt_next  = cnt_reg + CNT_W'(1);
            addr_next = addr_reg + ADDR_W'(BURST_PIXELS * 2);
            if (cnt_reg == CNT_W'(BURSTS - 1)) state_next = DONE;
            else if (!enable)                  state_next = IDLE;
            else                               state_next = WAIT_SPACE;
          end
        end
      end
      DONE: begin
        if (enable && fs)  state_next = FLUSH;
        else if (!enable)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      cnt_reg       <= '0;
      late_reg      <= 1'b0;
      restart_reg   <= 1'b0;
      vsync_d_reg   <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      cnt_reg       <= cnt_next;
      late_reg      <= late_next;
      restart_reg   <= restart_next;
      vsync_d_reg   <= vsync_in;
      underflow_reg <= underflow_reg | (fifo_rd_en & fifo_empty & frame_active);
    end
  end

  assign cmd_valid    = (state_reg == ISSUE);
  assign fifo_flush   = (state_reg == FLUSH);
  assign frame_active = (state_reg == FLUSH) || (state_reg == WAIT_SPACE) ||
                        (state_reg == ISSUE) || (state_reg == WAIT_DONE);
  assign cmd_addr     = addr_reg;
  assign cmd_len      = 8'(BURST_PIXELS - 1);
  assign underflow    = underflow_reg;
  assign late_frame   = late_reg;

endmodule

// File: tb/tb_frame_fetch_scheduler.sv
// Scenario-driven bench for frame_fetch_scheduler; the bench plays the AXI reader and FIFO, and
// predicts addresses and flags from frame geometry (base + 128 bytes per burst, 1200 bursts per frame).
module tb_frame_fetch_scheduler;
  logic        clk = 1'b0;
  logic        rst, enable, swap_req, vsync_in, fifo_empty, fifo_rd_en, cmd_ready, rd_done;
  logic [31:0] frame_base, frame_base_alt;
  logic [10:0] fifo_level;
  logic        cmd_valid, fifo_flush, frame_active, underflow, late_frame;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;

  int total = 0;
  int bad = 0;
  bit db;

  frame_fetch_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_base(frame_base),
    .frame_base_alt(frame_base_alt), .swap_req(swap_req), .vsync_in(vsync_in),
    .fifo_level(fifo_level), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_done(rd_done), .fifo_flush(fifo_flush), .frame_active(frame_active),
    .underflow(underflow), .late_frame(late_frame)
  );

  always #5 clk = ~clk;

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; enable = 1'b0; swap_req = 1'b0; vsync_in = 1'b1; fifo_empty = 1'b0;
    fifo_rd_en = 1'b0; cmd_ready = 1'b0; rd_done = 1'b0; fifo_level = '0;
    step(); step();
    rst = 1'b0;
    step(); step();
  endtask

  task automatic vsync_fall();
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
  endtask

  task automatic wait_cmd(output logic [31:0] addr, output bit timeout);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    timeout = (cmd_valid !== 1'b1);
    addr = cmd_addr;
  endtask

  task automatic handshake(input int delay);
    repeat (delay) step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
  endtask

  task automatic pulse_done(input int delay);
    repeat (delay) step();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
  endtask

  task automatic test_reset();
    int seen = 0;
    apply_reset();
    rst = 1'b1; enable = 1'b1; fifo_rd_en = 1'b1; fifo_empty = 1'b1; cmd_ready = 1'b1;
    step();
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got=%b want=0", cmd_valid); end
    total++; if (fifo_flush !== 1'b0) begin bad++; $display("FAIL reset_fifo_flush got=%b want=0", fifo_flush); end
    total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL reset_frame_active got=%b want=0", frame_active); end
    total++; if (underflow !== 1'b0 || late_frame !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", underflow, late_frame); end
    total++; if (cmd_addr !== 32'h0) begin bad++; $display("FAIL reset_cmd_addr got=%h want=0", cmd_addr); end
    total++; if (cmd_len !== 8'd63) begin bad++; $display("FAIL reset_cmd_len got=%0d want=63", cmd_len); end
    rst = 1'b0; fifo_rd_en = 1'b0; fifo_empty = 1'b0; cmd_ready = 1'b0;
    repeat (20) begin step(); if (cmd_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL reset_no_fs_no_cmd got=%0d want=0", seen); end
    $display("test_reset: done");
  endtask

  task automatic test_full_frame();
    logic [31:0] a, base;
    bit to;
    int hs = 0, errs = 0, seen = 0;
    apply_reset();
    enable = 1'b1; base = 32'h1000_0000; frame_base = base; frame_base_alt = 32'h0;
    vsync_fall();
    total++; if (fifo_flush !== 1'b1 || frame_active !== 1'b1) begin bad++; $display("FAIL frame_flush_start got=%b/%b want=1/1", fifo_flush, frame_active); end
    step();
    total++; if (fifo_flush !== 1'b0) begin bad++; $display("FAIL frame_flush_one_cycle got=%b want=0", fifo_flush); end
    for (int k = 0; k < 1200; k++) begin
      wait_cmd(a, to);
      if (to) break;
      if (a !== base + 32'(k * 128)) errs++;
      if (k == 0) begin
        total++; if (a !== 32'h1000_0000) begin bad++; $display("FAIL frame_first_addr got=%h want=10000000", a); end
      end
      if (k == 1) begin
        total++; if (a !== 32'h1000_0080) begin bad++; $display("FAIL frame_second_addr got=%h want=10000080", a); end
      end
      if (k == 1199) begin
        total++; if (a !== 32'h1002_5780) begin bad++; $display("FAIL frame_last_addr got=%h want=10025780", a); end
      end
      handshake($urandom_range(0, 2));
      hs++;
      pulse_done(19);
      if (k == 1198) begin
        total++; if (frame_active !== 1'b1) begin bad++; $display("FAIL frame_active_before_last got=%b want=1", frame_active); end
      end
      if (k == 1199) begin
        total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL frame_active_after_last got=%b want=0", frame_active); end
      end
    end
    total++; if (hs !== 1200) begin bad++; $display("FAIL frame_handshakes got=%0d want=1200", hs); end
    total++; if (errs !== 0) begin bad++; $display("FAIL frame_addr_sequence got=%0d errors want=0", errs); end
    repeat (30) begin step(); if (cmd_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL frame_no_cmd_after_done got=%0d want=0", seen); end
    $display("test_full_frame: handshakes=%0d", hs);
  endtask

  task automatic test_space_gate();
    logic [31:0] a, base;
    bit to, stable, expv;
    int seen = 0, lvl;
    apply_reset();
    enable = 1'b1; base = 32'h1000_0000; frame_base = base; fifo_level = 11'd961;
    vsync_fall();
    repeat (10) begin step(); if (cmd_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL space_961_blocked got=%0d want=0", seen); end
    fifo_level = 11'd960;
    step();
    total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL space_960_issue got=%b want=1", cmd_valid); end
    stable = 1'b1;
    repeat (5) begin
      step();
      if (cmd_valid !== 1'b1 || cmd_addr !== base) stable = 1'b0;
    end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL space_hold_stable got=%b/%h want=1/%h", cmd_valid, cmd_addr, base); end
    handshake(0);
    pulse_done($urandom_range(1, 8));
    for (int i = 0; i < 12; i++) begin
      lvl = $urandom_range(930, 1000);
      fifo_level = 11'(lvl);
      repeat (4) step();
      expv = ((1024 - lvl) >= 64);
      total++; if (cmd_valid !== expv) begin bad++; $display("FAIL space_random level=%0d got=%b want=%b", lvl, cmd_valid, expv); end
      fifo_level = '0;
      wait_cmd(a, to);
      total++; if (to || a !== base + 32'((i + 1) * 128)) begin bad++; $display("FAIL space_random_addr got=%h want=%h", a, base + 32'((i + 1) * 128)); end
      handshake($urandom_range(0, 3));
      pulse_done($urandom_range(1, 10));
    end
    $display("test_space_gate: done");
  endtask

  task automatic test_late_vsync();
    logic [31:0] a, base;
    bit to;
    int errs = 0, seen = 0;
    apply_reset();
    enable = 1'b1; base = $urandom & 32'hFFFF_FFC0; frame_base = base;
    vsync_fall();
    for (int k = 0; k < 100; k++) begin
      wait_cmd(a, to);
      if (to || a !== base + 32'(k * 128)) errs++;
      handshake($urandom_range(0, 2));
      pulse_done($urandom_range(1, 6));
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL late_prefix_addrs got=%0d errors want=0", errs); end
    total++; if (late_frame !== 1'b0) begin bad++; $display("FAIL late_before got=%b want=0", late_frame); end
    wait_cmd(a, to);
    handshake(0);
    step(); step();
    vsync_fall();
    total++; if (late_frame !== 1'b1) begin bad++; $display("FAIL late_in_wait_done got=%b want=1", late_frame); end
    repeat (8) begin step(); if (cmd_valid || fifo_flush) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL late_hold_until_done got=%0d want=0", seen); end
    rd_done = 1'b1; step(); rd_done = 1'b0;
    total++; if (fifo_flush !== 1'b1) begin bad++; $display("FAIL late_flush_after_done got=%b want=1", fifo_flush); end
    wait_cmd(a, to);
    total++; if (to || a !== base) begin bad++; $display("FAIL late_restart_addr got=%h want=%h", a, base); end
    handshake(1);
    pulse_done(3);
    wait_cmd(a, to);
    total++; if (to || a !== base + 32'd128) begin bad++; $display("FAIL late_restart_second got=%h want=%h", a, base + 32'd128); end
    handshake(0);
    fifo_level = 11'd1024;
    pulse_done(2);
    step(); step(); step();
    vsync_fall();
    total++; if (fifo_flush !== 1'b1) begin bad++; $display("FAIL late_in_wait_space_flush got=%b want=1", fifo_flush); end
    fifo_level = '0;
    wait_cmd(a, to);
    total++; if (to || a !== base) begin bad++; $display("FAIL late_wait_space_addr got=%h want=%h", a, base); end
    $display("test_late_vsync: base=%h", base);
  endtask

  task automatic test_underflow();
    bit re, em, expu;
    apply_reset();
    enable = 1'b1; frame_base = 32'h1000_0000; fifo_level = 11'd1024;
    fifo_rd_en = 1'b1; fifo_empty = 1'b1;
    repeat (3) step();
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL underflow_idle got=%b want=0", underflow); end
    fifo_rd_en = 1'b0; fifo_empty = 1'b0;
    vsync_fall();
    expu = 1'b0;
    for (int i = 0; i < 16; i++) begin
      re = 1'($urandom); em = 1'($urandom);
      if (i == 15) begin re = 1'b1; em = 1'b1; end
      fifo_rd_en = re; fifo_empty = em;
      step();
      expu = expu | (re & em);
      total++; if (underflow !== expu) begin bad++; $display("FAIL underflow_cycle%0d got=%b want=%b", i, underflow, expu); end
    end
    fifo_rd_en = 1'b0; fifo_empty = 1'b0;
    vsync_fall();
    repeat (3) step();
    total++; if (underflow !== 1'b1 || late_frame !== 1'b1) begin bad++; $display("FAIL underflow_sticky got=%b/%b want=1/1", underflow, late_frame); end
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL underflow_cleared got=%b want=0", underflow); end
    $display("test_underflow: done");
  endtask

  task automatic test_swap();
    logic [31:0] a, base, alt, expa;
    bit to, sel;
    apply_reset();
    enable = 1'b1; base = 32'h1000_0000; alt = 32'h2000_0000;
    frame_base = base; frame_base_alt = alt; sel = 1'b0;
    vsync_fall();
    for (int f = 0; f < 5; f++) begin
      wait_cmd(a, to);
      expa = sel ? alt : base;
      total++; if (to || a !== expa) begin bad++; $display("FAIL swap_frame%0d_addr got=%h want=%h", f, a, expa); end
      handshake(0);
      pulse_done(2);
      if (f == 0) begin
        swap_req = 1'b1; step(); swap_req = 1'b0;
        if (db) sel = ~sel;
      end
      wait_cmd(a, to);
      vsync_fall();
      // A request landing in the flush cycle belongs to the frame after this one.
      if (f == 2) begin
        swap_req = 1'b1; step(); swap_req = 1'b0;
      end
      if (f == 3 && db) sel = ~sel;
    end
    $display("test_swap: double_buffer=%0d", db);
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] a;
    bit to;
    int seen = 0;
    apply_reset();
    enable = 1'b1; frame_base = 32'h1000_0000;
    vsync_fall();
    wait_cmd(a, to);
    fifo_rd_en = 1'b1; fifo_empty = 1'b1; step(); fifo_rd_en = 1'b0; fifo_empty = 1'b0;
    vsync_fall();
    wait_cmd(a, to);
    total++; if (to || underflow !== 1'b1 || late_frame !== 1'b1) begin bad++; $display("FAIL midrst_precondition got=%b/%b/%b want=1/1/1", cmd_valid, underflow, late_frame); end
    rst = 1'b1; step();
    total++; if (cmd_valid !== 1'b0 || frame_active !== 1'b0) begin bad++; $display("FAIL midrst_outputs got=%b/%b want=0/0", cmd_valid, frame_active); end
    total++; if (underflow !== 1'b0 || late_frame !== 1'b0 || cmd_addr !== 32'h0) begin bad++; $display("FAIL midrst_flags got=%b/%b/%h want=0/0/0", underflow, late_frame, cmd_addr); end
    rst = 1'b0;
    repeat (50) begin step(); if (cmd_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_cmd got=%0d want=0", seen); end
    $display("test_reset_mid_burst: done");
  endtask

  initial begin
`ifdef DOUBLE_BUFFER_EN
    db = 1'b1;
`else
    db = 1'b0;
`endif
    frame_base = '0; frame_base_alt = '0;
    test_reset();
    test_space_gate();
    test_late_vsync();
    test_underflow();
    test_swap();
    test_reset_mid_burst();
    test_full_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
